// File: rtl/lpm_matcher.sv
// Longest-prefix-match lookup stage: checks a parsed header for IPv4 and scans a
// CPU-programmed route table one entry per cycle. Byte k of every byte vector is bits [8k+7:8k].
module lpm_matcher #(
  parameter int HDR_MAX_LEN = 64,
  parameter int MAX_VAL_LEN = 8,
  parameter int NUM_PORTS   = 4,
  parameter int N_ENTRIES   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [8*HDR_MAX_LEN-1:0]     pkt_hdr_i,
  input  logic [NUM_PORTS-1:0]         dflt_port_i,
  output logic                         busy_o,
  input  logic                         cfg_we_i,
  input  logic [$clog2(N_ENTRIES)-1:0] cfg_idx_i,
  input  logic                         cfg_valid_i,
  input  logic [31:0]                  cfg_prefix_i,
  input  logic [5:0]                   cfg_plen_i,
  input  logic [8*MAX_VAL_LEN-1:0]     cfg_val_i,
  output logic                         start_o,
  output logic [8*HDR_MAX_LEN-1:0]     pkt_hdr_o,
  output logic                         is_match_o,
  output logic [8*MAX_VAL_LEN-1:0]     args_o,
  output logic [NUM_PORTS-1:0]         out_port_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int HDR_W = 8 * HDR_MAX_LEN;
  localparam int VAL_W = 8 * MAX_VAL_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [5:0]       PLEN_MAX = 6'd32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [5:0] clamp_plen(input logic [5:0] plen);
    logic [5:0] r;
    if (plen > PLEN_MAX) begin
      r = PLEN_MAX;
    end else begin
      r = plen;
    end
    return r;
  endfunction

  // plen 0 yields an all-zero mask, so a valid /0 entry matches every address.
  function automatic logic [31:0] prefix_mask(input logic [5:0] plen);
    logic [31:0] m;
    if (plen >= PLEN_MAX) begin
      m = 32'hFFFF_FFFF;
    end else begin
      m = ~(32'hFFFF_FFFF >> plen);
    end
    return m;
  endfunction

  function automatic logic is_ipv4(input logic [HDR_W-1:0] hdr);
    return (hdr[8*12 +: 8] == 8'h08) && (hdr[8*13 +: 8] == 8'h00) &&
           (hdr[8*14+4 +: 4] == 4'h4);
  endfunction

  function automatic logic [31:0] dst_addr(input logic [HDR_W-1:0] hdr);
    return {hdr[8*30 +: 8], hdr[8*31 +: 8], hdr[8*32 +: 8], hdr[8*33 +: 8]};
  endfunction

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 best_found;
  logic                 best_found_nxt;
  logic [5:0]           best_plen;
  logic [5:0]           best_plen_nxt;
  logic [VAL_W-1:0]     best_args;
  logic [VAL_W-1:0]     best_args_nxt;
  logic [HDR_W-1:0]     hdr_q;
  logic [HDR_W-1:0]     hdr_nxt;
  logic [NUM_PORTS-1:0] dflt_q;
  logic [NUM_PORTS-1:0] dflt_nxt;

  logic                 tbl_valid  [N_ENTRIES];
  logic [31:0]          tbl_prefix [N_ENTRIES];
  logic [5:0]           tbl_plen   [N_ENTRIES];
  logic [VAL_W-1:0]     tbl_val    [N_ENTRIES];

  logic [31:0]          cur_dst;
  logic                 cur_hit;
  logic                 cur_take;
  logic                 fold_found;
  logic [5:0]           fold_plen;
  logic [VAL_W-1:0]     fold_args;

  logic                 res_valid;
  logic [HDR_W-1:0]     res_hdr;
  logic                 res_match;
  logic [VAL_W-1:0]     res_args;
  logic [NUM_PORTS-1:0] res_port;

  // Route table: CPU writes land next cycle; reset invalidates and zeroes every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_prefix[i] <= 32'h0;
        tbl_plen[i]   <= 6'd0;
        tbl_val[i]    <= '0;
      end
    end else if (cfg_we_i) begin
      tbl_valid[cfg_idx_i]  <= cfg_valid_i;
      tbl_prefix[cfg_idx_i] <= cfg_prefix_i;
      tbl_plen[cfg_idx_i]   <= clamp_plen(cfg_plen_i);
      tbl_val[cfg_idx_i]    <= cfg_val_i;
    end
  end

  // Compare the current entry and fold it into best-so-far; strict > keeps the lower index on ties.
  always_comb begin
    cur_dst  = dst_addr(hdr_q);
    cur_hit  = tbl_valid[idx] &&
               (((cur_dst ^ tbl_prefix[idx]) & prefix_mask(tbl_plen[idx])) == 32'h0);
    cur_take = cur_hit && (!best_found || (tbl_plen[idx] > best_plen));
    if (cur_take) begin
      fold_found = 1'b1;
      fold_plen  = tbl_plen[idx];
      fold_args  = tbl_val[idx];
    end else begin
      fold_found = best_found;
      fold_plen  = best_plen;
      fold_args  = best_args;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, scan bookkeeping and result formation.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    best_found_nxt = best_found;
    best_plen_nxt  = best_plen;
    best_args_nxt  = best_args;
    hdr_nxt        = hdr_q;
    dflt_nxt       = dflt_q;
    res_valid      = 1'b0;
    res_hdr        = hdr_q;
    res_match      = 1'b0;
    res_args       = '0;
    res_port       = dflt_q;
    case (state)
      IDLE: begin
        if (start_i) begin
          hdr_nxt        = pkt_hdr_i;
          dflt_nxt       = dflt_port_i;
          idx_nxt        = '0;
          best_found_nxt = 1'b0;
          best_plen_nxt  = 6'd0;
          best_args_nxt  = '0;
          if (is_ipv4(pkt_hdr_i)) begin
            state_nxt = SCAN;
          end else begin
            // Non-IPv4 headers bypass the table and report a miss immediately.
            res_valid = 1'b1;
            res_hdr   = pkt_hdr_i;
            res_port  = dflt_port_i;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        best_found_nxt = fold_found;
        best_plen_nxt  = fold_plen;
        best_args_nxt  = fold_args;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          res_valid = 1'b1;
          res_match = fold_found;
          if (fold_found) begin
            res_args = fold_args;
            res_port = fold_args[8*6 +: NUM_PORTS];
          end else begin
            res_args = '0;
            res_port = dflt_q;
          end
        end else begin
          idx_nxt = idx + IDX_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Scan datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      best_found <= 1'b0;
      best_plen  <= 6'd0;
      best_args  <= '0;
      hdr_q      <= '0;
      dflt_q     <= '0;
    end else begin
      idx        <= idx_nxt;
      best_found <= best_found_nxt;
      best_plen  <= best_plen_nxt;
      best_args  <= best_args_nxt;
      hdr_q      <= hdr_nxt;
      dflt_q     <= dflt_nxt;
    end
  end

  // Result registers: only the start_o cycle refreshes them, so they hold between lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_o    <= 1'b0;
      busy_o     <= 1'b0;
      pkt_hdr_o  <= '0;
      is_match_o <= 1'b0;
      args_o     <= '0;
      out_port_o <= '0;
    end else begin
      start_o <= res_valid;
      busy_o  <= (state_nxt == SCAN);
      if (res_valid) begin
        pkt_hdr_o  <= res_hdr;
        is_match_o <= res_match;
        args_o     <= res_args;
        out_port_o <= res_port;
      end
    end
  end

endmodule

// File: tb/tb_lpm_matcher.sv
// Scoreboard bench for lpm_matcher: stimulus pushes expected results, a negedge monitor checks them.
module tb_lpm_matcher;

  localparam int HW = 512;
  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [HW-1:0] pkt_hdr_i = '0;
  logic [3:0]    dflt_port_i = 4'd0;
  logic          busy_o;
  logic          cfg_we_i = 1'b0;
  logic [3:0]    cfg_idx_i = 4'd0;
  logic          cfg_valid_i = 1'b0;
  logic [31:0]   cfg_prefix_i = 32'h0;
  logic [5:0]    cfg_plen_i = 6'd0;
  logic [VW-1:0] cfg_val_i = '0;
  logic          start_o;
  logic [HW-1:0] pkt_hdr_o;
  logic          is_match_o;
  logic [VW-1:0] args_o;
  logic [3:0]    out_port_o;

  lpm_matcher dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pkt_hdr_i(pkt_hdr_i),
    .dflt_port_i(dflt_port_i), .busy_o(busy_o), .cfg_we_i(cfg_we_i),
    .cfg_idx_i(cfg_idx_i), .cfg_valid_i(cfg_valid_i), .cfg_prefix_i(cfg_prefix_i),
    .cfg_plen_i(cfg_plen_i), .cfg_val_i(cfg_val_i), .start_o(start_o),
    .pkt_hdr_o(pkt_hdr_o), .is_match_o(is_match_o), .args_o(args_o),
    .out_port_o(out_port_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic          m;
    logic [VW-1:0] a;
    logic [3:0]    p;
    logic [HW-1:0] h;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [VW-1:0] mk_args(input logic [3:0] idx, input logic [3:0] port);
    logic [VW-1:0] a;
    for (int j = 0; j < 8; j++) a[8*j +: 8] = {idx, 4'(j)};
    a[8*6 +: 8] = {4'h0, port};
    return a;
  endfunction

  function automatic logic [HW-1:0] mk_hdr(input logic [15:0] et, input logic [3:0] ver,
                                          input logic [31:0] dst);
    logic [HW-1:0] h;
    for (int k = 0; k < 64; k++) h[8*k +: 8] = 8'(k) ^ 8'hA5;
    h[8*12 +: 8] = et[15:8];
    h[8*13 +: 8] = et[7:0];
    h[8*14 +: 8] = {ver, 4'h5};
    h[8*30 +: 8] = dst[31:24];
    h[8*31 +: 8] = dst[23:16];
    h[8*32 +: 8] = dst[15:8];
    h[8*33 +: 8] = dst[7:0];
    return h;
  endfunction

  // Monitor: every start_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (start_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_start_o at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", HW'(cyc), HW'(e.at));
        chk("is_match", HW'(is_match_o), HW'(e.m));
        chk("args", HW'(args_o), HW'(e.a));
        chk("out_port", HW'(out_port_o), HW'(e.p));
        chk("pkt_hdr", pkt_hdr_o, e.h);
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [HW-1:0] h, input logic [3:0] d, input bit push,
                       input bit ipv4, input logic m, input logic [VW-1:0] a,
                       input logic [3:0] p, output int t);
    exp_t e;
    t = cyc;
    start_i = 1'b1;
    pkt_hdr_i = h;
    dflt_port_i = d;
    if (push) begin
      e.at = t + (ipv4 ? 17 : 1);
      e.m = m;
      e.a = a;
      e.p = p;
      e.h = h;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic v, input logic [31:0] pfx,
                           input logic [5:0] plen, input logic [VW-1:0] val);
    cfg_we_i = 1'b1;
    cfg_idx_i = idx;
    cfg_valid_i = v;
    cfg_prefix_i = pfx;
    cfg_plen_i = plen;
    cfg_val_i = val;
    @(posedge clk);
    #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL result_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  localparam logic [15:0] ET4 = 16'h0800;

  initial begin
    int t;
    logic [HW-1:0] h;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_start_o", HW'(start_o), HW'(1'b0));
    chk("rst_busy_o", HW'(busy_o), HW'(1'b0));
    chk("rst_is_match", HW'(is_match_o), HW'(1'b0));
    chk("rst_args", HW'(args_o), HW'(64'h0));
    chk("rst_out_port", HW'(out_port_o), HW'(4'h0));
    chk("rst_pkt_hdr", pkt_hdr_o, {HW{1'b0}});

    // Empty table: miss with default port, plus busy window.
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0001, 1'b1, 1'b1, 1'b0, 64'h0, 4'b0001, t);
    chk("busy_scan_start", HW'(busy_o), HW'(1'b1));
    wait_to(t + 16);
    chk("busy_scan_last", HW'(busy_o), HW'(1'b1));
    wait_to(t + 17);
    chk("busy_after_result", HW'(busy_o), HW'(1'b0));
    wait_done(40);

    // /8 vs /16: longer prefix wins.
    cfg_write(4'd3, 1'b1, 32'h0A000000, 6'd8, mk_args(4'd3, 4'b0010));
    cfg_write(4'd9, 1'b1, 32'h0A010000, 6'd16, mk_args(4'd9, 4'b0100));
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd9, 4'b0100), 4'b0100, t);
    wait_done(40);

    // Remove entries (idx3 rewritten invalid with a /32 that would otherwise win).
    cfg_write(4'd3, 1'b0, 32'h0A010909, 6'd32, mk_args(4'd3, 4'b0010));
    cfg_write(4'd9, 1'b0, 32'h0A010000, 6'd16, mk_args(4'd9, 4'b0100));
    cfg_write(4'd1, 1'b1, 32'h0A010000, 6'd16, mk_args(4'd1, 4'b0010));
    cfg_write(4'd5, 1'b1, 32'h0A010000, 6'd16, mk_args(4'd5, 4'b0100));
    cfg_write(4'd0, 1'b1, 32'h00000000, 6'd0, mk_args(4'd0, 4'b1000));
    issue(mk_hdr(ET4, 4'h4, 32'h0A010909), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd1, 4'b0010), 4'b0010, t);
    wait_done(40);
    issue(mk_hdr(ET4, 4'h4, 32'hC0A80001), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd0, 4'b1000), 4'b1000, t);
    wait_done(40);
    // plen 40 clamps to an exact /32 match.
    cfg_write(4'd7, 1'b1, 32'h0A010909, 6'd40, mk_args(4'd7, 4'b0001));
    issue(mk_hdr(ET4, 4'h4, 32'h0A010909), 4'b0010, 1'b1, 1'b1, 1'b1,
          mk_args(4'd7, 4'b0001), 4'b0001, t);
    wait_done(40);
    issue(mk_hdr(ET4, 4'h4, 32'h0A010908), 4'b0010, 1'b1, 1'b1, 1'b1,
          mk_args(4'd1, 4'b0010), 4'b0010, t);
    wait_done(40);

    // Non-IPv4: EtherType 0x86DD, then version nibble 6.
    issue(mk_hdr(16'h86DD, 4'h4, 32'h0A010909), 4'b0100, 1'b1, 1'b0, 1'b0, 64'h0, 4'b0100, t);
    chk("busy_non_ipv4_et", HW'(busy_o), HW'(1'b0));
    wait_done(10);
    issue(mk_hdr(ET4, 4'h6, 32'h0A010909), 4'b1000, 1'b1, 1'b0, 1'b0, 64'h0, 4'b1000, t);
    chk("busy_non_ipv4_ver", HW'(busy_o), HW'(1'b0));
    wait_done(10);

    // Starts during a scan and on its last cycle are dropped; next start at T+17 accepted.
    issue(mk_hdr(ET4, 4'h4, 32'h0A010909), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd7, 4'b0001), 4'b0001, t);
    wait_to(t + 5);
    issue(mk_hdr(ET4, 4'h4, 32'hC0A80001), 4'b0010, 1'b0, 1'b1, 1'b0, 64'h0, 4'b0, t);
    wait_to(t - 5 + 16);
    issue(mk_hdr(16'h86DD, 4'h4, 32'h0), 4'b0010, 1'b0, 1'b0, 1'b0, 64'h0, 4'b0, t);
    issue(mk_hdr(ET4, 4'h4, 32'hC0A80001), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd0, 4'b1000), 4'b1000, t);
    wait_done(60);

    // Reset mid-scan aborts the lookup and clears the table.
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0001, 1'b0, 1'b1, 1'b0, 64'h0, 4'b0, t);
    wait_to(t + 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", HW'(busy_o), HW'(1'b0));
    chk("abort_is_match", HW'(is_match_o), HW'(1'b0));
    wait_to(t + 30);
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0010, 1'b1, 1'b1, 1'b0, 64'h0, 4'b0010, t);
    wait_done(40);

    // Writes during a scan: idx0 written on its own compare cycle (old contents used), idx15 later.
    cfg_write(4'd3, 1'b1, 32'h0A000000, 6'd8, mk_args(4'd3, 4'b0010));
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0001, 1'b1, 1'b1, 1'b1,
          mk_args(4'd15, 4'b1000), 4'b1000, t);
    cfg_write(4'd0, 1'b1, 32'h0A010203, 6'd32, mk_args(4'd0, 4'b0001));
    wait_to(t + 3);
    cfg_write(4'd15, 1'b1, 32'h0A010200, 6'd24, mk_args(4'd15, 4'b1000));
    wait_done(40);
    issue(mk_hdr(ET4, 4'h4, 32'h0A010203), 4'b0100, 1'b1, 1'b1, 1'b1,
          mk_args(4'd0, 4'b0001), 4'b0001, t);
    wait_done(40);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", HW'(sb.size()), HW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
